ysyx_25040111_mem_arbiter: RTL

- Shares the single core memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- LSU requests come from the execute stage's memory outputs: enable, write, wdata, addr, mask and sign.
- One outstanding transaction at a time.
- LSU has priority over IFU, with a starvation guard that protects IFU.
- A response timeout watchdog returns an error to the owner if memory never answers.

---
 rtl/ysyx_25040111_mem_arbiter_pkg.sv | 37 +++
 rtl/ysyx_25040111_mem_arbiter_pick.sv | 53 +++++
 rtl/ysyx_25040111_mem_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040111_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM state encodings,
// owner IDs, access-size codes (shared with the execute unit), the latched
// request payload and common widths.
package ysyx_25040111_mem_arbiter_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MASK_W   = 2;
  localparam int unsigned TCNT_W   = 16;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_REPLY = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_e;

  typedef enum logic [MASK_W-1:0] {
    MASK_BYTE = 2'b00,
    MASK_HALF = 2'b01,
    MASK_WORD = 2'b10
  } mask_size_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mask;
  } mem_req_t;

endpackage

// File: rtl/ysyx_25040111_mem_arbiter_pick.sv
// Requester picker with IFU starvation guard.
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   enable                arbiter is able to accept a request this cycle
//   ifu_valid, lsu_valid  pending requests
//   grant_ifu, grant_lsu  combinational one-hot grant (also the handshake,
//                         since a grant is only given to a valid requester)
module ysyx_25040111_arb_pick
  import ysyx_25040111_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic ifu_valid,
  input  logic lsu_valid,
  output logic grant_ifu,
  output logic grant_lsu
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;
  logic                force_ifu;

  // LSU wins by default; IFU wins when LSU is idle or it has waited too long.
  always_comb begin
    force_ifu = ifu_valid && (starve_q == LIMIT);
    grant_lsu = enable && lsu_valid && !force_ifu;
    grant_ifu = enable && ifu_valid && (!lsu_valid || force_ifu);
    starve_d  = starve_q;
    if (grant_ifu) begin
      starve_d = '0;
    end else if (grant_lsu) begin
      if (!ifu_valid) begin
        starve_d = '0;
      end else if (starve_q != LIMIT) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/ysyx_25040111_mem_arbiter.sv
// Shares the single core memory port between the IFU (read-only) and the
// LSU (read/write). One transaction in flight; LSU priority with an IFU
// starvation guard; a response watchdog replies with an error if memory
// never answers, and the late response is then drained before new grants.
// Ports:
//   clock, reset                      clock, asynchronous active-high reset
//   ifu_req_* / ifu_addr              IFU request channel
//   ifu_rsp_* / ifu_rdata / ifu_rerr  IFU response channel
//   lsu_req_* / lsu_addr/write/wdata/mask  LSU request channel
//   lsu_rsp_* / lsu_rdata / lsu_rerr  LSU response channel (raw load data)
//   mem_req_* / mem_addr/write/wdata/mask  memory request channel
//   mem_rsp_* / mem_rdata / mem_rerr  memory response channel
//   arb_owner                         current/last owner: 0 IFU, 1 LSU
module ysyx_25040111_mem_arbiter
  import ysyx_25040111_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rerr,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_write,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_mask,
  output logic              lsu_rsp_valid,
  input  logic              lsu_rsp_ready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rerr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_mask,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rerr,
  output logic              arb_owner
);

  localparam bit                TO_EN     = (TIMEOUT != 0);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  mem_req_t          req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rerr_q, rerr_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              drop_q, drop_d;
  logic              pick_en;
  logic              grant_ifu, grant_lsu;
  logic              rsp_take;

  // Grants only in IDLE with no stale response outstanding.
  assign pick_en = (state_q == ST_IDLE) && !drop_q && !reset;

  ysyx_25040111_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clock    (clock),
    .reset    (reset),
    .enable   (pick_en),
    .ifu_valid(ifu_req_valid),
    .lsu_valid(lsu_req_valid),
    .grant_ifu(grant_ifu),
    .grant_lsu(grant_lsu)
  );

  assign rsp_take = (owner_q == OWNER_IFU) ? ifu_rsp_ready : lsu_rsp_ready;

  // Next-state and next-datapath logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    tcnt_d  = tcnt_q;
    drop_d  = drop_q;

    // A response arriving after a timeout belongs to nobody; swallow it.
    if (drop_q && mem_rsp_valid && (state_q != ST_WAIT)) begin
      drop_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (grant_lsu) begin
          req_d   = '{addr: lsu_addr, write: lsu_write, wdata: lsu_wdata, mask: lsu_mask};
          owner_d = OWNER_LSU;
          state_d = ST_ISSUE;
        end else if (grant_ifu) begin
          req_d   = '{addr: ifu_addr, write: 1'b0, wdata: '0, mask: MASK_WORD};
          owner_d = OWNER_IFU;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_req_ready) begin
          tcnt_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          rdata_d = mem_rdata;
          rerr_d  = mem_rerr;
          state_d = ST_REPLY;
        end else if (TO_EN && (tcnt_q == TCNT_LAST)) begin
          rdata_d = '0;
          rerr_d  = 1'b1;
          drop_d  = 1'b1;
          state_d = ST_REPLY;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      ST_REPLY: begin
        if (rsp_take) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_IFU;
      req_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      tcnt_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      tcnt_q  <= tcnt_d;
      drop_q  <= drop_d;
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  assign mem_req_valid = (state_q == ST_ISSUE);
  assign mem_addr      = req_q.addr;
  assign mem_write     = req_q.write;
  assign mem_wdata     = req_q.wdata;
  assign mem_mask      = req_q.mask;
  assign mem_rsp_ready = (state_q == ST_WAIT) || drop_q;

  assign ifu_rsp_valid = (state_q == ST_REPLY) && (owner_q == OWNER_IFU);
  assign lsu_rsp_valid = (state_q == ST_REPLY) && (owner_q == OWNER_LSU);
  assign ifu_rdata     = rdata_q;
  assign lsu_rdata     = rdata_q;
  assign ifu_rerr      = rerr_q && (owner_q == OWNER_IFU);
  assign lsu_rerr      = rerr_q && (owner_q == OWNER_LSU);
  assign arb_owner     = owner_q;

endmodule
